// File: rtl/fetch_queue.sv
// Fetch queue between IF and ID: circular FIFO of {pc, inst} with flush and occupancy count.
// Optional same-cycle empty-queue forwarding enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    input  logic [31:0]              push_pc,
    input  logic [31:0]              push_inst,
    output logic                     push_ready,
    output logic                     pop_valid,
    output logic [31:0]              pop_pc,
    output logic [31:0]              pop_inst,
    input  logic                     pop_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];

    logic stored_valid_c;
    logic bypass_c;
    logic push_fire_c;
    logic pop_fire_c;

    assign stored_valid_c = (count_q != '0) && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue with a consumer ready: hand the fetched word straight through, never stored.
    assign bypass_c = (count_q == '0) && push_valid && pop_ready && !flush;
`else
    assign bypass_c = 1'b0;
`endif

    assign push_ready  = (count_q != FULL_CNT) && !flush;
    assign pop_valid   = stored_valid_c || bypass_c;
    assign push_fire_c = push_valid && push_ready && !bypass_c;
    assign pop_fire_c  = stored_valid_c && pop_ready;
    assign count       = count_q;

    // Head entry to ID; zero (NOP) whenever nothing is valid.
    always_comb begin
        pop_pc   = '0;
        pop_inst = '0;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (bypass_c) begin
            pop_pc   = push_pc;
            pop_inst = push_inst;
        end else if (stored_valid_c) begin
            pop_pc   = pc_mem[rd_ptr_q];
            pop_inst = inst_mem[rd_ptr_q];
        end
`else
        if (stored_valid_c) begin
            pop_pc   = pc_mem[rd_ptr_q];
            pop_inst = inst_mem[rd_ptr_q];
        end
`endif
    end

    // Pointer and occupancy update; flush wins over any handshake in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_fire_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_fire_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_fire_c, pop_fire_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_fire_c) begin
            pc_mem[wr_ptr_q]   <= push_pc;
            inst_mem[wr_ptr_q] <= push_inst;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table plus hand sequences, queue scoreboard.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        push_valid;
    logic [31:0] push_pc;
    logic [31:0] push_inst;
    logic        push_ready;
    logic        pop_valid;
    logic [31:0] pop_pc;
    logic [31:0] pop_inst;
    logic        pop_ready;
    logic        flush;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb[$];

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_pc    (push_pc),
        .push_inst  (push_inst),
        .push_ready (push_ready),
        .pop_valid  (pop_valid),
        .pop_pc     (pop_pc),
        .pop_inst   (pop_inst),
        .pop_ready  (pop_ready),
        .flush      (flush),
        .count      (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One cycle: drive, compare combinational outputs against the scoreboard, advance the model.
    task automatic cycle(input logic pv, input logic [31:0] pc, input logic [31:0] inst,
                         input logic pr, input logic fl);
        logic        exp_pr;
        logic        exp_sv;
        logic        byp;
        logic [63:0] head;
        push_valid = pv;
        push_pc    = pc;
        push_inst  = inst;
        pop_ready  = pr;
        flush      = fl;
        #1;
        exp_pr = (sb.size() != DEPTH) && !fl;
        exp_sv = (sb.size() != 0) && !fl;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (sb.size() == 0) && pv && pr && !fl;
`else
        byp = 1'b0;
`endif
        head = byp ? {pc, inst} : (exp_sv ? sb[0] : 64'h0);
        check("push_ready", 32'(push_ready), 32'(exp_pr));
        check("pop_valid",  32'(pop_valid),  32'(exp_sv || byp));
        check("pop_pc",     pop_pc,   head[63:32]);
        check("pop_inst",   pop_inst, head[31:0]);
        check("count",      32'(count), 32'(sb.size()));
        if (fl) begin
            sb.delete();
        end else begin
            if (exp_sv && pr && !byp) void'(sb.pop_front());
            if (pv && exp_pr && !byp) sb.push_back({pc, inst});
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pr;
        logic        fl;
        int          cnt_after;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 32'h100, 32'hA000_0000, 1'b0, 1'b0, 1};
        vecs[1] = '{1'b1, 32'h104, 32'hA000_0001, 1'b0, 1'b0, 2};
        vecs[2] = '{1'b0, 32'h0,   32'h0,         1'b1, 1'b0, 1};
        vecs[3] = '{1'b1, 32'h108, 32'hA000_0002, 1'b1, 1'b0, 1};
        vecs[4] = '{1'b0, 32'h0,   32'h0,         1'b1, 1'b0, 0};
        vecs[5] = '{1'b0, 32'h0,   32'h0,         1'b1, 1'b0, 0};
        vecs[6] = '{1'b1, 32'h10C, 32'hA000_0003, 1'b0, 1'b1, 0};
        vecs[7] = '{1'b0, 32'h0,   32'h0,         1'b0, 1'b0, 0};

        rst        = 1'b1;
        push_valid = 1'b0;
        push_pc    = '0;
        push_inst  = '0;
        pop_ready  = 1'b0;
        flush      = 1'b0;
        @(negedge clk);
        #1;
        check("rst_count",      32'(count),      32'd0);
        check("rst_pop_valid",  32'(pop_valid),  32'd0);
        check("rst_pop_inst",   pop_inst,        32'd0);
        check("rst_push_ready", 32'(push_ready), 32'd1);
        rst = 1'b0;

        // Table: first row pushes on the first edge after reset release.
        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].pv, vecs[i].pc, vecs[i].inst, vecs[i].pr, vecs[i].fl);
            check($sformatf("tbl_count_%0d", i), 32'(count), 32'(vecs[i].cnt_after));
        end

        // Fill to full with ID stalled, overflow attempt, then in-order drain.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i * 4), 32'h1000 + 32'(i), 1'b0, 1'b0);
        #1;
        check("full_count",      32'(count),      32'd4);
        check("full_push_ready", 32'(push_ready), 32'd0);
        cycle(1'b1, 32'h10, 32'hDEAD, 1'b0, 1'b0);
        check("overflow_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_order", pop_pc, 32'(i * 4));
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        check("drained_count", 32'(count), 32'd0);

        // Full with push and pop offered together: push refused, accepted next cycle.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h180 + 32'(i * 4), 32'h2000 + 32'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'h200, 32'h2222, 1'b1, 1'b0);
        check("full_pushpop_count", 32'(count), 32'd3);
        cycle(1'b1, 32'h200, 32'h2222, 1'b1, 1'b0);
        check("retry_count", 32'(count), 32'd3);
        check("retry_tail", sb[sb.size() - 1][63:32], 32'h200);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Steady state at two entries with push+pop every cycle across several wraps.
        cycle(1'b1, 32'h300, 32'h3000, 1'b0, 1'b0);
        cycle(1'b1, 32'h304, 32'h3001, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'h308 + 32'(i * 4), 32'h3002 + 32'(i), 1'b1, 1'b0);
            check("steady_count", 32'(count), 32'd2);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with a concurrent push at count 3: everything, including the push, is lost.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h400 + 32'(i * 4), 32'h4000 + 32'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'h40C, 32'h4003, 1'b0, 1'b1);
        check("flush_count", 32'(count), 32'd0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream at count 3, observed before any clock edge.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h500 + 32'(i * 4), 32'h5000 + 32'(i), 1'b0, 1'b0);
        push_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_count",     32'(count),     32'd0);
        check("async_pop_valid", 32'(pop_valid), 32'd0);
        check("async_pop_inst",  pop_inst,       32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 32'h600, 32'h6000, 1'b0, 1'b0);
        check("post_rst_count", 32'(count), 32'd1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Empty-queue push with ID ready: same-cycle forward or one cycle later.
        cycle(1'b1, 32'h700, 32'h8C01_0004, 1'b1, 1'b0);
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        check("empty_push_next_inst", pop_inst, 32'h0);
`else
        check("empty_push_next_inst", pop_inst, 32'h8C01_0004);
`endif
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
